// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator
// Sums a block of N signed products from the Booth multiplier into a wider
// signed accumulator. The finished sum is offered on a valid/ready handshake.
// The optional macro ACC_SATURATE_EN makes an overflowing add clamp to the
// signed range instead of wrapping. The ovf flag is set in both builds.
//
// state | meaning
// IDLE  | waiting for start; last result still visible on acc_out
// ACCUM | accepting products until N transfers have completed
// DONE  | result valid, waiting for acc_ready
module booth_product_accumulator #(
  parameter int PW = 8,
  parameter int AW = 12,
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [PW-1:0] prod_in,
  input  logic                 prod_valid,
  output logic                 prod_ready,
  output logic signed [AW-1:0] acc_out,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic [CW-1:0]        count,
  output logic                 busy,
  output logic                 ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state;

  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] sum_wrap;
  logic signed [AW-1:0] sum_next;
  logic                 add_ovf;

  // Sign-extend the product, add, and flag a signed overflow on this add
  always_comb begin
    prod_ext = AW'(prod_in);
    sum_wrap = acc_out + prod_ext;
    add_ovf  = (acc_out[AW-1] == prod_ext[AW-1]) && (sum_wrap[AW-1] != acc_out[AW-1]);
    sum_next = sum_wrap;
`ifdef ACC_SATURATE_EN
    if (add_ovf) begin
      // both operands share a sign, so acc_out's sign picks the rail
      sum_next = acc_out[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
`endif
  end

  assign prod_ready = (state == ACCUM);
  assign busy       = (state != IDLE);

  // Block sequencing, accumulation and the result handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      count     <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_out <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc_out <= sum_next;
            count   <= count + CW'(1);
            if (add_ovf) ovf <= 1'b1;
            if (count == CW'(N - 1)) begin
              acc_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          // start is deliberately ignored here; only acc_ready releases the block
          if (acc_ready) begin
            acc_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench for booth_product_accumulator: default build, an AW=8
// instance for overflow, and an N=1 instance for the single-product block.
module tb_booth_product_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // instance a: default parameters
  logic               start_a = 0, pv_a = 0, ar_a = 0;
  logic signed [7:0]  prod_a = 0;
  logic               pr_a, av_a, busy_a, ovf_a;
  logic signed [11:0] acc_a;
  logic [2:0]         cnt_a;

  // instance b: AW=8
  logic               start_b = 0, pv_b = 0, ar_b = 0;
  logic signed [7:0]  prod_b = 0;
  logic               pr_b, av_b, busy_b, ovf_b;
  logic signed [7:0]  acc_b;
  logic [2:0]         cnt_b;

  // instance c: N=1
  logic               start_c = 0, pv_c = 0, ar_c = 0;
  logic signed [7:0]  prod_c = 0;
  logic               pr_c, av_c, busy_c, ovf_c;
  logic signed [11:0] acc_c;
  logic [0:0]         cnt_c;

  booth_product_accumulator u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .prod_in(prod_a), .prod_valid(pv_a),
    .prod_ready(pr_a), .acc_out(acc_a), .acc_valid(av_a), .acc_ready(ar_a),
    .count(cnt_a), .busy(busy_a), .ovf(ovf_a)
  );

  booth_product_accumulator #(.PW(8), .AW(8), .N(4), .CW(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .prod_in(prod_b), .prod_valid(pv_b),
    .prod_ready(pr_b), .acc_out(acc_b), .acc_valid(av_b), .acc_ready(ar_b),
    .count(cnt_b), .busy(busy_b), .ovf(ovf_b)
  );

  booth_product_accumulator #(.PW(8), .AW(12), .N(1), .CW(1)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .prod_in(prod_c), .prod_valid(pv_c),
    .prod_ready(pr_c), .acc_out(acc_c), .acc_valid(av_c), .acc_ready(ar_c),
    .count(cnt_c), .busy(busy_c), .ovf(ovf_c)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int d[4]   = '{15, -6, -36, 1};
  int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
  int k;
  int exp_sat;

  initial begin
    // reset state
    @(negedge clk);
    check("rst_acc", acc_a, 0);
    check("rst_valid", av_a, 0);
    check("rst_ready", pr_a, 0);
    check("rst_count", cnt_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_ovf", ovf_a, 0);
    rst = 0;
    @(negedge clk);

    // back-to-back block
    ar_a = 1; start_a = 1;
    @(negedge clk);
    start_a = 0;
    check("t1_ready", pr_a, 1);
    check("t1_busy", busy_a, 1);
    for (int i = 0; i < 4; i++) begin
      pv_a = 1; prod_a = 8'(d[i]);
      @(negedge clk);
    end
    pv_a = 0;
    check("t1_valid", av_a, 1);
    check("t1_acc", acc_a, -26);
    check("t1_count", cnt_a, 4);
    check("t1_ovf", ovf_a, 0);
    check("t1_ready_done", pr_a, 0);
    @(negedge clk);
    check("t1_valid_idle", av_a, 0);
    check("t1_busy_idle", busy_a, 0);
    check("t1_acc_hold", acc_a, -26);

    // gapped valid, stalled acc_ready
    ar_a = 0; start_a = 1;
    @(negedge clk);
    start_a = 0;
    check("t2_acc_clr", acc_a, 0);
    check("t2_cnt_clr", cnt_a, 0);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      pv_a = pat[i][0];
      prod_a = (pat[i] != 0) ? 8'(d[k]) : 8'sd100;
      if (pat[i] != 0) k++;
      @(negedge clk);
    end
    pv_a = 0;
    for (int i = 0; i < 5; i++) begin
      check("t2_valid_stall", av_a, 1);
      check("t2_acc_stall", acc_a, -26);
      @(negedge clk);
    end
    ar_a = 1;
    @(negedge clk);
    check("t2_valid_rel", av_a, 0);

    // start pulsed mid-block
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    pv_a = 1; prod_a = 8'sd15;  @(negedge clk);
    pv_a = 1; prod_a = -8'sd6;  @(negedge clk);
    pv_a = 0; start_a = 1;      @(negedge clk);
    start_a = 0;
    check("t3_cnt_mid", cnt_a, 2);
    check("t3_acc_mid", acc_a, 9);
    check("t3_busy_mid", busy_a, 1);
    pv_a = 1; prod_a = -8'sd36; @(negedge clk);
    pv_a = 1; prod_a = 8'sd1;   @(negedge clk);
    pv_a = 0;
    check("t3_acc", acc_a, -26);
    check("t3_valid", av_a, 1);
    @(negedge clk);

    // asynchronous reset mid-block
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    pv_a = 1; prod_a = 8'sd15; @(negedge clk);
    pv_a = 1; prod_a = -8'sd6; @(negedge clk);
    pv_a = 0;
    #2 rst = 1;
    #1;
    check("t4_acc_rst", acc_a, 0);
    check("t4_cnt_rst", cnt_a, 0);
    check("t4_busy_rst", busy_a, 0);
    check("t4_ready_rst", pr_a, 0);
    @(negedge clk);
    rst = 0;
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    for (int i = 0; i < 4; i++) begin
      pv_a = 1; prod_a = 8'sd64;
      @(negedge clk);
    end
    pv_a = 0;
    check("t4_acc", acc_a, 256);
    check("t4_valid", av_a, 1);
    check("t4_ovf", ovf_a, 0);
    @(negedge clk);

    // overflow in an 8-bit accumulator
`ifdef ACC_SATURATE_EN
    exp_sat = 127;
`else
    exp_sat = 0;
`endif
    ar_b = 1; start_b = 1;
    @(negedge clk);
    start_b = 0;
    for (int i = 0; i < 4; i++) begin
      pv_b = 1; prod_b = 8'sd64;
      @(negedge clk);
    end
    pv_b = 0;
    check("t5_acc", acc_b, exp_sat);
    check("t5_ovf", ovf_b, 1);
    check("t5_valid", av_b, 1);
    @(negedge clk);

    // N=1: second product ignored, start+acc_ready in DONE
    ar_c = 0; start_c = 1;
    @(negedge clk);
    start_c = 0;
    pv_c = 1; prod_c = 8'sd7;
    @(negedge clk);
    check("t6_valid", av_c, 1);
    check("t6_acc", acc_c, 7);
    check("t6_ready_done", pr_c, 0);
    check("t6_count", cnt_c, 1);
    @(negedge clk);
    check("t6_acc_ign", acc_c, 7);
    check("t6_valid_hold", av_c, 1);
    pv_c = 0; start_c = 1; ar_c = 1;
    @(negedge clk);
    start_c = 0;
    check("t6_valid_rel", av_c, 0);
    check("t6_busy_rel", busy_c, 0);
    check("t6_acc_keep", acc_c, 7);
    @(negedge clk);
    check("t6_no_restart", busy_c, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
